aes_job_sched: RTL and testbench

AES_JOB_SCHED -- requirements
Module: aes_job_sched

---
 rtl/aes_sched_pkg.sv | 13 +
 rtl/aes_rr_arb.sv | 17 +
 rtl/aes_job_sched.sv | 95 +++++++++
 tb/tb_aes_job_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: shared widths, FSM states and the latched job record for the AES job scheduler.
package aes_sched_pkg;
    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BUSY, S_RESP} state_t;

    typedef struct packed {
        logic                 mode;
        logic [AES_BLK_W-1:0] key;
        logic [AES_BLK_W-1:0] text;
        logic                 id;
    } job_t;
endpackage

// File: rtl/aes_rr_arb.sv
// aes_rr_arb: 2-way round-robin arbiter; the pointer flips to the other requester after each grant.
module aes_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);
    logic ptr;

    always_ff @(posedge clk or negedge rst)
        if (!rst) ptr <= 1'b0;
        else if (adv) ptr <= ~gnt[1];

    // a lone requester wins outright; the pointer only breaks ties
    always_comb gnt = (&req) ? {ptr, ~ptr} : req;
endmodule

// File: rtl/aes_job_sched.sv
// aes_job_sched: schedules jobs from two requesters onto one AES engine, one job in flight.
// Define AES_SCHED_WDOG_EN to abort a stuck engine after TIMEOUT_CYC busy cycles (rsp_err=1).
module aes_job_sched
    import aes_sched_pkg::*;
#(
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_mode,
    input  logic [2*AES_BLK_W-1:0] req_key,
    input  logic [2*AES_BLK_W-1:0] req_text,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [AES_BLK_W-1:0]   rsp_text,
    output logic                   rsp_err,
    output logic                   eng_ld,
    output logic                   eng_mode,
    output logic [AES_BLK_W-1:0]   eng_key,
    output logic [AES_BLK_W-1:0]   eng_text,
    input  logic [AES_BLK_W-1:0]   eng_text_out,
    input  logic                   eng_done
);
    state_t     state, state_nx;
    job_t       job;
    logic [1:0] gnt;
    logic       acc, gid, fin, timeout;

    aes_rr_arb u_arb (
        .clk(clk),
        .rst(rst),
        .req(req_valid),
        .adv(acc),
        .gnt(gnt)
    );

    // gated by rst so the ready outputs drop the moment reset is asserted
    assign req_ready = (rst && state == S_IDLE) ? gnt : 2'b00;
    assign acc       = |req_ready;
    assign gid       = gnt[1];
    assign fin       = state == S_BUSY && (eng_done || timeout);

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= S_IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        state_nx = (state == S_IDLE) ? (acc ? S_LOAD : S_IDLE) :
                   (state == S_LOAD) ? S_BUSY :
                   (state == S_BUSY) ? (fin ? S_RESP : S_BUSY) :
                   (rsp_ready ? S_IDLE : S_RESP);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) job <= '0;
        else if (acc) job <= '{mode: req_mode[gid],
                               key:  gid ? req_key[2*AES_BLK_W-1:AES_BLK_W] : req_key[AES_BLK_W-1:0],
                               text: gid ? req_text[2*AES_BLK_W-1:AES_BLK_W] : req_text[AES_BLK_W-1:0],
                               id:   gid};

    always_ff @(posedge clk or negedge rst)
        if (!rst) rsp_text <= '0;
        else if (fin) rsp_text <= eng_done ? eng_text_out : '0;

`ifdef AES_SCHED_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rst)
        if (!rst) wd_cnt <= '0;
        else if (state == S_LOAD) wd_cnt <= '0;
        else if (state == S_BUSY) wd_cnt <= wd_cnt + 1'b1;

    // the last tolerated busy cycle is the one where the count would reach TIMEOUT_CYC
    assign timeout = state == S_BUSY && !eng_done && wd_cnt == WD_W'(TIMEOUT_CYC - 1);

    always_ff @(posedge clk or negedge rst)
        if (!rst) rsp_err <= 1'b0;
        else if (fin) rsp_err <= !eng_done;
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign rsp_valid = state == S_RESP;
    assign rsp_id    = job.id;
    assign eng_ld    = state == S_LOAD;
    assign eng_mode  = job.mode;
    assign eng_key   = job.key;
    assign eng_text  = job.text;
endmodule

// File: tb/tb_aes_job_sched.sv
// tb_aes_job_sched: randomized scoreboard bench with a behavioural engine and arbitration model.
// Watchdog scenario is exercised when AES_SCHED_WDOG_EN is defined.
module tb_aes_job_sched;
    localparam int TO = 32;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_SCHED_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic clk = 0, rst = 0;
    logic [1:0] req_valid = 0, req_ready, req_mode = 0;
    logic [255:0] req_key = 0, req_text = 0;
    logic rsp_valid, rsp_ready = 0, rsp_id, rsp_err, eng_ld, eng_mode, eng_done;
    logic [127:0] rsp_text, eng_key, eng_text, eng_text_out;

    always #5 clk = ~clk;

    aes_job_sched #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_key(req_key), .req_text(req_text),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_text(rsp_text), .rsp_err(rsp_err),
        .eng_ld(eng_ld), .eng_mode(eng_mode), .eng_key(eng_key), .eng_text(eng_text),
        .eng_text_out(eng_text_out), .eng_done(eng_done)
    );

    typedef struct { logic id; logic [127:0] text; logic err; } rsp_t;
    rsp_t sb[$];
    logic grant_log[$];

    int checks = 0, errors = 0, cyc = 0;
    int acc_cnt = 0, done_cnt = 0, last_hs = -1, ld_cyc = -10, acc_cyc = 0, tgt = 0;
    int eng_delay = 0;
    bit stray_en = 1, auto_gen = 0, keep_both = 0, hold_rsp = 0, ptr_m = 0;
    logic [1:0] pend = 0;
    logic m[2];
    logic [127:0] k[2], t[2];
    logic ld_m;
    logic [127:0] ld_k, ld_t, last_text;
    logic last_id, last_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // stand-in engine: known answers for the reference vectors, a keyed mix otherwise
    function automatic logic [127:0] eng_fn(logic md, logic [127:0] ky, logic [127:0] tx);
        if (ky == K0 && !md && tx == P0) return C0;
        if (ky == K0 && md && tx == C0) return P0;
        return md ? (tx ^ {ky[63:0], ky[127:64]}) : (tx ^ ky ^ {4{32'h5a3c96e1}});
    endfunction

    initial begin
        int cnt = 0;
        logic [127:0] res = 0;
        eng_done = 0;
        eng_text_out = 0;
        forever begin
            @(negedge clk);
            if (eng_ld) begin
                cnt = eng_delay < 0 ? -1 : eng_delay > 0 ? eng_delay : int'($urandom_range(1, 6));
                res = eng_fn(eng_mode, eng_key, eng_text);
            end
            @(posedge clk);
            #1;
            if (cnt > 0) begin
                cnt--;
                eng_done = cnt == 0;
                eng_text_out = eng_done ? res : {$urandom(), $urandom(), $urandom(), $urandom()};
            end else begin
                eng_done = cnt == 0 && stray_en && $urandom_range(0, 9) == 0;
                eng_text_out = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("eng_ld", eng_ld, cyc == ld_cyc);
            if (eng_ld) begin
                check("eng_mode", eng_mode, ld_m);
                check("eng_key", eng_key, ld_k);
                check("eng_text", eng_text, ld_t);
            end
            if (rsp_valid) begin
                check("req_ready_in_resp", req_ready, 0);
                if (sb.size() == 0) check("rsp_unexpected", rsp_valid, 0);
                else begin
                    check("rsp_id", rsp_id, sb[0].id);
                    check("rsp_text", rsp_text, sb[0].text);
                    check("rsp_err", rsp_err, sb[0].err);
                    if (rsp_ready) begin
                        last_id = rsp_id;
                        last_text = rsp_text;
                        last_err = rsp_err;
                        void'(sb.pop_front());
                        done_cnt++;
                        last_hs = cyc;
                    end
                end
            end
        end
    end

    task automatic drive();
        req_valid = pend;
        req_mode = {m[1], m[0]};
        req_key = {k[1], k[0]};
        req_text = {t[1], t[0]};
    endtask

    task automatic new_job(int i);
        pend[i] = 1'b1;
        m[i] = 1'($urandom_range(0, 1));
        k[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        t[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic step();
        logic [1:0] exp_r;
        rsp_t e;
        int w;
        @(negedge clk);
        #1;
        exp_r = 2'b00;
        if (acc_cnt == done_cnt && last_hs < cyc && pend != 0) begin
            w = (pend == 2'b11) ? ptr_m : (pend[1] ? 1 : 0);
            exp_r[w] = 1'b1;
        end
        check("req_ready", req_ready, exp_r);
        if (req_ready != 0) grant_log.push_back(req_ready[1]);
        if (exp_r != 0) begin
            w = exp_r[1] ? 1 : 0;
            e.id = exp_r[1];
            e.err = eng_delay < 0 && WDOG;
            e.text = e.err ? '0 : eng_fn(m[w], k[w], t[w]);
            sb.push_back(e);
            acc_cnt++;
            acc_cyc = cyc;
            ld_cyc = cyc + 1;
            {ld_m, ld_k, ld_t} = {m[w], k[w], t[w]};
            ptr_m = w == 0;
            pend[w] = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            if (!pend[i] && ((auto_gen && $urandom_range(0, 2) == 0) || (keep_both && acc_cnt < tgt)))
                new_job(i);
        rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
        drive();
    endtask

    task automatic run_jobs(int n);
        int guard = 0;
        tgt = acc_cnt + n;
        while (!(acc_cnt >= tgt && pend == 0 && done_cnt == acc_cnt)) begin
            if (acc_cnt >= tgt) auto_gen = 0;
            step();
            guard++;
            if (guard > 3000) begin
                checks++;
                errors++;
                $display("FAIL run_jobs_timeout: accepted %0d completed %0d", acc_cnt, done_cnt);
                break;
            end
        end
    endtask

    task automatic do_reset(int n);
        rst = 0;
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_text", rsp_text, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_eng_ld", eng_ld, 0);
        check("rst_eng_mode", eng_mode, 0);
        check("rst_eng_key", eng_key, 0);
        check("rst_eng_text", eng_text, 0);
        pend = 0;
        drive();
        sb.delete();
        acc_cnt = done_cnt;
        ptr_m = 0;
        ld_cyc = -10;
        repeat (n) @(posedge clk);
        #1 rst = 1;
    endtask

    initial begin
        int guard, a0, nrsp;
        logic [127:0] snap_text;
        logic snap_id;
        for (int i = 0; i < 2; i++) begin
            m[i] = 0;
            k[i] = 0;
            t[i] = 0;
        end
        @(posedge clk);
        #1;
        do_reset(2);

        m[0] = 0; k[0] = K0; t[0] = P0; pend[0] = 1; drive();
        run_jobs(0);
        check("kat_enc_id", last_id, 0);
        check("kat_enc_text", last_text, C0);
        check("kat_enc_err", last_err, 0);

        m[1] = 1; k[1] = K0; t[1] = C0; pend[1] = 1; drive();
        run_jobs(0);
        check("kat_dec_id", last_id, 1);
        check("kat_dec_text", last_text, P0);

        do_reset(2);
        grant_log.delete();
        keep_both = 1;
        new_job(0); new_job(1); drive();
        run_jobs(4);
        keep_both = 0;
        check("rr_count", grant_log.size() >= 4, 1);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) check("rr_order", grant_log[i], i % 2);

        auto_gen = 1;
        run_jobs(40);

        hold_rsp = 1; rsp_ready = 0;
        new_job(1); drive();
        guard = 0;
        while (!rsp_valid && guard < 60) begin step(); guard++; end
        check("bp_rsp_seen", rsp_valid, 1);
        snap_text = rsp_text;
        snap_id = rsp_id;
        new_job(0); drive();
        repeat (10) begin
            step();
            check("bp_valid", rsp_valid, 1);
            check("bp_text", rsp_text, snap_text);
            check("bp_id", rsp_id, snap_id);
            check("bp_req_ready", req_ready, 0);
        end
        hold_rsp = 0;
        run_jobs(0);

        eng_delay = 15;
        new_job(0); drive();
        a0 = acc_cnt; guard = 0;
        while (acc_cnt == a0 && guard < 20) begin step(); guard++; end
        repeat (3) step();
        do_reset(2);
        nrsp = 0;
        repeat (25) begin step(); if (rsp_valid) nrsp++; end
        check("reset_no_rsp", nrsp, 0);
        eng_delay = 0;
        new_job(1); drive();
        run_jobs(0);
        check("post_reset_id", last_id, 1);
        check("post_reset_text", last_text, eng_fn(m[1], k[1], t[1]));

        eng_delay = -1;
        new_job(0); drive();
`ifdef AES_SCHED_WDOG_EN
        a0 = acc_cnt; guard = 0;
        while (acc_cnt == a0 && guard < 20) begin step(); guard++; end
        guard = 0;
        while (!rsp_valid && guard < 80) begin step(); guard++; end
        check("wdog_latency", cyc - acc_cyc, 34);
        check("wdog_err", rsp_err, 1);
        check("wdog_text", rsp_text, 0);
        run_jobs(0);
        eng_delay = 0;
`else
        repeat (60) step();
        check("hang_no_rsp", rsp_valid, 0);
        do_reset(2);
        eng_delay = 0;
`endif
        auto_gen = 1;
        run_jobs(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, %0d errors so far", errors);
        $fatal(1);
    end
endmodule
